id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding muxes and ALU-control decode.
// Forwarding and decode are combinational on the registered stage contents.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] id_read_data_1,
  input  logic [DATA_W-1:0] id_read_data_2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_valid
);

  logic [DATA_W-1:0] rd1_reg, rd2_reg, imm_reg;
  logic [REG_AW-1:0] rs_reg, rt_reg, rd_reg;
  logic [5:0]        funct_reg;
  logic [1:0]        alu_op_reg;
  logic              alu_src_reg, reg_dst_reg, reg_write_reg;
  logic              mem_read_reg, mem_write_reg, mem_to_reg_reg, valid_reg;

  // Flush outranks stall so a squashed instruction can never be held in EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush) begin
      rd1_reg        <= '0;
      rd2_reg        <= '0;
      imm_reg        <= '0;
      rs_reg         <= '0;
      rt_reg         <= '0;
      rd_reg         <= '0;
      funct_reg      <= '0;
      alu_op_reg     <= '0;
      alu_src_reg    <= 1'b0;
      reg_dst_reg    <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      valid_reg      <= 1'b0;
    end else if (!stall) begin
      rd1_reg        <= id_read_data_1;
      rd2_reg        <= id_read_data_2;
      imm_reg        <= id_imm;
      rs_reg         <= id_rs;
      rt_reg         <= id_rt;
      rd_reg         <= id_rd;
      funct_reg      <= id_funct;
      alu_op_reg     <= id_alu_op;
      alu_src_reg    <= id_alu_src;
      reg_dst_reg    <= id_reg_dst;
      reg_write_reg  <= id_reg_write;
      mem_read_reg   <= id_mem_read;
      mem_write_reg  <= id_mem_write;
      mem_to_reg_reg <= id_mem_to_reg;
      valid_reg      <= 1'b1;
    end
  end

  // Operand 0 is rs, operand 1 is rt; the nearer stage (EX/MEM) wins, $0 never forwards.
  logic [DATA_W-1:0] src_data [2];
  logic [REG_AW-1:0] src_spec [2];
  logic [DATA_W-1:0] fwd_data [2];

  assign src_data[0] = rd1_reg;
  assign src_data[1] = rd2_reg;
  assign src_spec[0] = rs_reg;
  assign src_spec[1] = rt_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic hit_exmem, hit_memwb;
    assign hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_spec[gi]);
    assign hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_spec[gi]);
    assign fwd_data[gi] = hit_exmem ? exmem_result :
                          hit_memwb ? memwb_result : src_data[gi];
  end

  always_comb begin
    alu_control = 3'd2;
    case (alu_op_reg)
      2'b01: alu_control = 3'd6;
      2'b10: begin
        case (funct_reg)
          6'b100000: alu_control = 3'd2;
          6'b100010: alu_control = 3'd6;
          6'b100100: alu_control = 3'd0;
          6'b100101: alu_control = 3'd1;
          6'b101010: alu_control = 3'd7;
          default:   alu_control = 3'd2;
        endcase
      end
      default: alu_control = 3'd2;
    endcase
  end

  assign alu_a         = fwd_data[0];
  assign ex_store_data = fwd_data[1];
  assign alu_b         = alu_src_reg ? imm_reg : fwd_data[1];
  assign ex_write_reg  = reg_dst_reg ? rd_reg : rt_reg;
  assign ex_rs         = rs_reg;
  assign ex_rt         = rt_reg;
  assign ex_reg_write  = reg_write_reg;
  assign ex_mem_read   = mem_read_reg;
  assign ex_mem_write  = mem_write_reg;
  assign ex_mem_to_reg = mem_to_reg_reg;
  assign ex_valid      = valid_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of directed capture/forward/decode vectors plus
// hand-written reset, stall, flush and reset-during-stall sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n, stall, flush;
  logic [31:0] id_read_data_1, id_read_data_2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_control;
  logic [4:0]  ex_write_reg, ex_rs, ex_rt;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_valid(ex_valid)
  );

  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [1:0]  alu_op;
    logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    logic        xm_we;
    logic [4:0]  xm_rd;
    logic [31:0] xm_res;
    logic        mw_we;
    logic [4:0]  mw_rd;
    logic [31:0] mw_res;
    logic [31:0] exp_a, exp_b, exp_store;
    logic [2:0]  exp_ctl;
    logic [4:0]  exp_wreg;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_read_data_1 = v.rd1;  id_read_data_2 = v.rd2;  id_imm = v.imm;
    id_rs = v.rs;  id_rt = v.rt;  id_rd = v.rd;
    id_funct = v.funct;  id_alu_op = v.alu_op;
    id_alu_src = v.alu_src;  id_reg_dst = v.reg_dst;  id_reg_write = v.reg_write;
    id_mem_read = v.mem_read;  id_mem_write = v.mem_write;  id_mem_to_reg = v.mem_to_reg;
    exmem_reg_write = v.xm_we;  exmem_rd = v.xm_rd;  exmem_result = v.xm_res;
    memwb_reg_write = v.mw_we;  memwb_rd = v.mw_rd;  memwb_result = v.mw_res;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 1'b0;
    memwb_reg_write = 1'b0;
  endtask

  task automatic fill_table();
    vec_t v;
    // add r3,r1,r2 with no forwarding
    v = '0; v.rd1 = 5; v.rd2 = 7; v.rs = 1; v.rt = 2; v.rd = 3; v.funct = 6'h20; v.alu_op = 2'b10;
    v.reg_dst = 1; v.reg_write = 1;
    v.exp_a = 5; v.exp_b = 7; v.exp_store = 7; v.exp_ctl = 2; v.exp_wreg = 3; vecs[0] = v;
    // both stages match rs: EX/MEM wins
    v = '0; v.rd1 = 32'h11; v.rd2 = 32'h22; v.rs = 4; v.rt = 5; v.rd = 6; v.funct = 6'h22; v.alu_op = 2'b10;
    v.reg_dst = 1; v.reg_write = 1; v.xm_we = 1; v.xm_rd = 4; v.xm_res = 32'h100;
    v.mw_we = 1; v.mw_rd = 4; v.mw_res = 32'h200;
    v.exp_a = 32'h100; v.exp_b = 32'h22; v.exp_store = 32'h22; v.exp_ctl = 6; v.exp_wreg = 6; vecs[1] = v;
    // same, EX/MEM not writing: MEM/WB forwards
    v = vecs[1]; v.xm_we = 0; v.funct = 6'h24; v.exp_a = 32'h200; v.exp_ctl = 0; vecs[2] = v;
    // $0 never forwarded
    v = '0; v.funct = 6'h25; v.alu_op = 2'b10; v.reg_write = 1; v.rd = 9;
    v.xm_we = 1; v.xm_rd = 0; v.xm_res = 32'hDEAD; v.mw_we = 1; v.mw_rd = 0; v.mw_res = 32'hBEEF;
    v.exp_a = 0; v.exp_b = 0; v.exp_store = 0; v.exp_ctl = 1; v.exp_wreg = 0; vecs[3] = v;
    // sw: immediate to ALU, forwarded rt to store data
    v = '0; v.rd1 = 32'h1000; v.rd2 = 32'h33; v.imm = 32'h10; v.rs = 8; v.rt = 9; v.rd = 1;
    v.alu_op = 2'b00; v.alu_src = 1; v.mem_write = 1; v.funct = 6'h2a;
    v.xm_we = 1; v.xm_rd = 7; v.xm_res = 32'h77; v.mw_we = 1; v.mw_rd = 9; v.mw_res = 32'h55;
    v.exp_a = 32'h1000; v.exp_b = 32'h10; v.exp_store = 32'h55; v.exp_ctl = 2; v.exp_wreg = 9; vecs[4] = v;
    // rs==rt, both forwarded from EX/MEM; slt
    v = '0; v.rd1 = 1; v.rd2 = 2; v.rs = 10; v.rt = 10; v.rd = 11; v.funct = 6'h2a; v.alu_op = 2'b10;
    v.reg_dst = 1; v.reg_write = 1; v.xm_we = 1; v.xm_rd = 10; v.xm_res = 32'hAAA;
    v.mw_we = 1; v.mw_rd = 10; v.mw_res = 32'hBBB;
    v.exp_a = 32'hAAA; v.exp_b = 32'hAAA; v.exp_store = 32'hAAA; v.exp_ctl = 7; v.exp_wreg = 11; vecs[5] = v;
    // rs from EX/MEM, rt from MEM/WB; unknown funct decodes to add
    v = '0; v.rd1 = 3; v.rd2 = 4; v.rs = 13; v.rt = 12; v.rd = 14; v.funct = 6'h3f; v.alu_op = 2'b10;
    v.reg_dst = 1; v.reg_write = 1; v.xm_we = 1; v.xm_rd = 13; v.xm_res = 32'h999;
    v.mw_we = 1; v.mw_rd = 12; v.mw_res = 32'h1234;
    v.exp_a = 32'h999; v.exp_b = 32'h1234; v.exp_store = 32'h1234; v.exp_ctl = 2; v.exp_wreg = 14; vecs[6] = v;
    // beq: subtract regardless of funct
    v = '0; v.rd1 = 9; v.rd2 = 9; v.rs = 2; v.rt = 3; v.rd = 4; v.funct = 6'h24; v.alu_op = 2'b01;
    v.exp_a = 9; v.exp_b = 9; v.exp_store = 9; v.exp_ctl = 6; v.exp_wreg = 3; vecs[7] = v;
    // alu_op 11 decodes to add; lw-style controls
    v = '0; v.rd1 = 32'hF0; v.rd2 = 32'h0F; v.rs = 5; v.rt = 6; v.rd = 7; v.funct = 6'h22; v.alu_op = 2'b11;
    v.mem_read = 1; v.mem_to_reg = 1; v.reg_write = 1;
    v.exp_a = 32'hF0; v.exp_b = 32'h0F; v.exp_store = 32'h0F; v.exp_ctl = 2; v.exp_wreg = 6; vecs[8] = v;
    // matching rd but write enables low: no forwarding
    v = '0; v.rd1 = 32'h44; v.rd2 = 32'h66; v.rs = 14; v.rt = 15; v.rd = 16; v.funct = 6'h25; v.alu_op = 2'b10;
    v.reg_dst = 1; v.xm_we = 0; v.xm_rd = 15; v.xm_res = 32'h1; v.mw_we = 0; v.mw_rd = 14; v.mw_res = 32'h2;
    v.exp_a = 32'h44; v.exp_b = 32'h66; v.exp_store = 32'h66; v.exp_ctl = 1; v.exp_wreg = 16; vecs[9] = v;
  endtask

  initial begin
    fill_table();
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(vecs[0]);
    id_read_data_1 = $urandom; id_read_data_2 = $urandom; id_rs = 5'($urandom);
    id_reg_write = 1'b1; id_mem_write = 1'b1; exmem_reg_write = 1'b1; exmem_rd = 5'($urandom);
    exmem_result = $urandom; memwb_reg_write = 1'b1; memwb_rd = 5'($urandom); memwb_result = $urandom;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", ex_valid, 0);
    check("rst_reg_write", ex_reg_write, 0);
    check("rst_mem_write", ex_mem_write, 0);
    check("rst_mem_read", ex_mem_read, 0);
    check("rst_alu_control", alu_control, 2);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_write_reg", ex_write_reg, 0);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_alu_a", i), alu_a, vecs[i].exp_a);
      check($sformatf("v%0d_alu_b", i), alu_b, vecs[i].exp_b);
      check($sformatf("v%0d_store", i), ex_store_data, vecs[i].exp_store);
      check($sformatf("v%0d_alu_control", i), alu_control, vecs[i].exp_ctl);
      check($sformatf("v%0d_write_reg", i), ex_write_reg, vecs[i].exp_wreg);
      check($sformatf("v%0d_ctrl", i), {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {1'b1, vecs[i].reg_write, vecs[i].mem_read, vecs[i].mem_write, vecs[i].mem_to_reg});
      check($sformatf("v%0d_rs_rt", i), {ex_rs, ex_rt}, {vecs[i].rs, vecs[i].rt});
    end

    // Stall holds contents while ID inputs change
    @(negedge clk); drive(vecs[0]);
    @(negedge clk); stall = 1'b1; drive(vecs[4]); no_fwd();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_alu_a", c), alu_a, 5);
      check($sformatf("stall%0d_alu_b", c), alu_b, 7);
      check($sformatf("stall%0d_write_reg", c), ex_write_reg, 3);
      check($sformatf("stall%0d_ctrl", c), {ex_valid, ex_reg_write, ex_mem_write}, 3'b110);
      @(negedge clk); drive(vecs[c + 5]); no_fwd();
    end

    // Flush wins over stall
    stall = 1'b0; drive(vecs[4]); no_fwd();
    @(posedge clk); #1;
    check("pre_flush_mem_write", ex_mem_write, 1);
    @(negedge clk); stall = 1'b1; flush = 1'b1; drive(vecs[0]); no_fwd();
    @(posedge clk); #1;
    check("flush_valid", ex_valid, 0);
    check("flush_reg_write", ex_reg_write, 0);
    check("flush_mem_write", ex_mem_write, 0);
    check("flush_alu_a", alu_a, 0);
    @(negedge clk); stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    check("post_flush_valid", ex_valid, 1);
    check("post_flush_alu_a", alu_a, 5);

    // Reset during stall clears immediately; capture resumes on release
    @(negedge clk); stall = 1'b1; drive(vecs[5]); no_fwd();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", ex_valid, 0);
    check("async_rst_reg_write", ex_reg_write, 0);
    check("async_rst_alu_a", alu_a, 0);
    @(negedge clk); reset_n = 1'b1; stall = 1'b0; drive(vecs[0]);
    @(posedge clk); #1;
    check("rst_release_valid", ex_valid, 1);
    check("rst_release_alu_a", alu_a, 5);
    check("rst_release_alu_b", alu_b, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
